// File: rtl/board_ram_responder.sv
// BattleShipX board RAM: 10x10 grid of 2-bit cells with edge-triggered
// read/write request handling, a display read port, clear sweep and ship count.
module board_ram_responder #(
    parameter int ROWS = 10,
    parameter int COLS = 10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] cursor,
    input  logic       ram_we,
    input  logic [7:0] wr_addr,
    input  logic [1:0] wr_val,
    output logic [1:0] rd_val,
    output logic       rd_valid,
    output logic       rd_oob,
    input  logic [7:0] vid_addr,
    output logic [1:0] vid_val,
    input  logic       clear,
    output logic       busy,
    output logic [6:0] ship_cells
);

    localparam int CELLS = ROWS * COLS;

    typedef enum logic {IDLE, CLEAR} state_t;

    function automatic logic on_board(input logic [7:0] a);
        return (int'(a[7:4]) < ROWS) && (int'(a[3:0]) < COLS);
    endfunction

    function automatic logic [6:0] idx_of(input logic [7:0] a);
        return 7'(int'(a[7:4]) * COLS + int'(a[3:0]));
    endfunction

    logic [1:0] mem_q [CELLS];
    logic [1:0] mem_d [CELLS];

    state_t     state_q, state_d;
    logic [6:0] sweep_q, sweep_d;
    logic [6:0] ship_q, ship_d;
    logic [7:0] last_cursor_q, last_cursor_d;
    logic [7:0] last_wr_addr_q, last_wr_addr_d;
    logic [1:0] last_wr_val_q, last_wr_val_d;
    logic       last_we_q, last_we_d;
    logic [1:0] rd_val_q, rd_val_d;
    logic       rd_valid_q, rd_valid_d;
    logic       rd_oob_q, rd_oob_d;
    logic [1:0] vid_val_q, vid_val_d;

    logic       rd_trig;
    logic       wr_trig;
    logic [6:0] wr_idx;
    logic [1:0] old_val;

    assign rd_trig = (state_q == IDLE) && !ram_we &&
                     ((cursor != last_cursor_q) || last_we_q);
    assign wr_trig = (state_q == IDLE) && ram_we &&
                     ((wr_addr != last_wr_addr_q) ||
                      (wr_val != last_wr_val_q) || !last_we_q);
    assign wr_idx  = idx_of(wr_addr);

    always_comb begin
        mem_d          = mem_q;
        state_d        = state_q;
        sweep_d        = sweep_q;
        ship_d         = ship_q;
        last_cursor_d  = last_cursor_q;
        last_wr_addr_d = last_wr_addr_q;
        last_wr_val_d  = last_wr_val_q;
        last_we_d      = last_we_q;
        rd_val_d       = 2'b00;
        rd_valid_d     = 1'b0;
        rd_oob_d       = 1'b0;
        old_val        = 2'b00;
        vid_val_d      = on_board(vid_addr) ? mem_q[idx_of(vid_addr)] : 2'b00;

        if (state_q == IDLE) begin
            last_we_d = ram_we;
        end

        if (rd_trig) begin
            last_cursor_d = cursor;
            rd_valid_d    = 1'b1;
            if (on_board(cursor)) begin
                rd_val_d = mem_q[idx_of(cursor)];
            end else begin
                rd_oob_d = 1'b1;
            end
        end

        if (wr_trig) begin
            last_wr_addr_d = wr_addr;
            last_wr_val_d  = wr_val;
            if (on_board(wr_addr)) begin
                old_val        = mem_q[wr_idx];
                mem_d[wr_idx]  = wr_val;
                if (old_val != 2'b01 && wr_val == 2'b01 &&
                    ship_q < 7'(CELLS)) begin
                    ship_d = ship_q + 7'd1;
                end else if (old_val == 2'b01 && wr_val != 2'b01 &&
                             ship_q != 7'd0) begin
                    ship_d = ship_q - 7'd1;
                end
            end
        end

        // Clear wins over a same-cycle write for the ship count.
        unique case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    sweep_d = 7'd0;
                    ship_d  = 7'd0;
                end
            end
            CLEAR: begin
                mem_d[sweep_q] = 2'b00;
                if (clear) begin
                    sweep_d = 7'd0;
                end else if (sweep_q == 7'(CELLS - 1)) begin
                    state_d = IDLE;
                end else begin
                    sweep_d = sweep_q + 7'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CELLS; i++) begin
                mem_q[i] <= 2'b00;
            end
            state_q        <= IDLE;
            sweep_q        <= 7'd0;
            ship_q         <= 7'd0;
            last_cursor_q  <= 8'hFF;
            last_wr_addr_q <= 8'hFF;
            last_wr_val_q  <= 2'b00;
            last_we_q      <= 1'b0;
            rd_val_q       <= 2'b00;
            rd_valid_q     <= 1'b0;
            rd_oob_q       <= 1'b0;
            vid_val_q      <= 2'b00;
        end else begin
            mem_q          <= mem_d;
            state_q        <= state_d;
            sweep_q        <= sweep_d;
            ship_q         <= ship_d;
            last_cursor_q  <= last_cursor_d;
            last_wr_addr_q <= last_wr_addr_d;
            last_wr_val_q  <= last_wr_val_d;
            last_we_q      <= last_we_d;
            rd_val_q       <= rd_val_d;
            rd_valid_q     <= rd_valid_d;
            rd_oob_q       <= rd_oob_d;
            vid_val_q      <= vid_val_d;
        end
    end

    assign rd_val     = rd_val_q;
    assign rd_valid   = rd_valid_q;
    assign rd_oob     = rd_oob_q;
    assign vid_val    = vid_val_q;
    assign busy       = (state_q == CLEAR);
    assign ship_cells = ship_q;

endmodule

// File: tb/tb_board_ram_responder.sv
// Directed vector bench for board_ram_responder: request edges, ship count,
// off-board handling, clear sweep timing and reset during a sweep.
module tb_board_ram_responder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] cursor = 8'hFF;
    logic       ram_we = 1'b0;
    logic [7:0] wr_addr = 8'hFF;
    logic [1:0] wr_val = 2'b00;
    logic [1:0] rd_val;
    logic       rd_valid;
    logic       rd_oob;
    logic [7:0] vid_addr = 8'h00;
    logic [1:0] vid_val;
    logic       clear = 1'b0;
    logic       busy;
    logic [6:0] ship_cells;

    int asserts = 0;
    int failures = 0;

    board_ram_responder #(.ROWS(10), .COLS(10)) dut (
        .clk(clk), .reset_n(reset_n), .cursor(cursor), .ram_we(ram_we),
        .wr_addr(wr_addr), .wr_val(wr_val), .rd_val(rd_val),
        .rd_valid(rd_valid), .rd_oob(rd_oob), .vid_addr(vid_addr),
        .vid_val(vid_val), .clear(clear), .busy(busy),
        .ship_cells(ship_cells)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         n;
        logic       we;
        logic [7:0] cur;
        logic [7:0] wa;
        logic [1:0] wv;
        logic [7:0] va;
        logic       e_valid;
        logic [1:0] e_val;
        logic       e_oob;
        logic [6:0] e_ship;
        logic [1:0] e_vid;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        asserts++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs [14];
    int   cnt;
    logic saw;

    initial begin
        //         n   we cur    wa     wv  va     vld val oob ship vid
        vecs[0]  = '{1,  0, 8'h00, 8'hFF, 0, 8'h00, 1, 0, 0, 0, 0};
        vecs[1]  = '{10, 0, 8'h00, 8'hFF, 0, 8'h00, 0, 0, 0, 0, 0};
        vecs[2]  = '{1,  1, 8'h00, 8'h23, 1, 8'h23, 0, 0, 0, 1, 0};
        vecs[3]  = '{1,  1, 8'h00, 8'h24, 1, 8'h23, 0, 0, 0, 2, 1};
        vecs[4]  = '{1,  1, 8'h00, 8'h25, 1, 8'h24, 0, 0, 0, 3, 1};
        vecs[5]  = '{1,  0, 8'h24, 8'h25, 1, 8'h25, 1, 1, 0, 3, 1};
        vecs[6]  = '{3,  0, 8'h24, 8'h25, 1, 8'h24, 0, 0, 0, 3, 1};
        vecs[7]  = '{1,  1, 8'h24, 8'h24, 2, 8'h24, 0, 0, 0, 2, 1};
        vecs[8]  = '{1,  0, 8'h24, 8'h24, 2, 8'h24, 1, 2, 0, 2, 2};
        vecs[9]  = '{1,  1, 8'h24, 8'h24, 2, 8'h24, 0, 0, 0, 2, 2};
        vecs[10] = '{1,  0, 8'h3A, 8'h24, 2, 8'h3A, 1, 0, 1, 2, 0};
        vecs[11] = '{1,  1, 8'h3A, 8'hA0, 1, 8'hA0, 0, 0, 0, 2, 0};
        vecs[12] = '{1,  1, 8'h3A, 8'h26, 1, 8'h26, 0, 0, 0, 3, 0};
        vecs[13] = '{1,  0, 8'h3A, 8'h26, 1, 8'h26, 1, 0, 1, 3, 1};

        #12;
        chk("reset rd_val", rd_val, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset rd_oob", rd_oob, 0);
        chk("reset vid_val", vid_val, 0);
        chk("reset busy", busy, 0);
        chk("reset ship", ship_cells, 0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 14; v++) begin
            ram_we   = vecs[v].we;
            cursor   = vecs[v].cur;
            wr_addr  = vecs[v].wa;
            wr_val   = vecs[v].wv;
            vid_addr = vecs[v].va;
            for (int k = 0; k < vecs[v].n; k++) begin
                tick();
                chk($sformatf("vec%0d.%0d rd_valid", v, k), rd_valid, vecs[v].e_valid);
                chk($sformatf("vec%0d.%0d rd_val", v, k), rd_val, vecs[v].e_val);
                chk($sformatf("vec%0d.%0d rd_oob", v, k), rd_oob, vecs[v].e_oob);
                chk($sformatf("vec%0d.%0d ship", v, k), ship_cells, vecs[v].e_ship);
                chk($sformatf("vec%0d.%0d vid_val", v, k), vid_val, vecs[v].e_vid);
            end
        end

        // Clear sweep: busy for 100 cycles, deferred read after it falls.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cursor = 8'h23;
        vid_addr = 8'h23;
        chk("clear busy rise", busy, 1);
        chk("clear ship zero", ship_cells, 0);
        cnt = 1;
        saw = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (rd_valid) saw = 1'b1;
            if (!busy) break;
            cnt++;
        end
        chk("clear busy cycles", cnt, 100);
        chk("no read during busy", saw, 0);
        tick();
        chk("post-clear rd_valid", rd_valid, 1);
        chk("post-clear rd_val", rd_val, 0);
        chk("post-clear rd_oob", rd_oob, 0);
        chk("post-clear vid 0x23", vid_val, 0);
        tick();
        chk("post-clear single pulse", rd_valid, 0);

        // Reset in the middle of a sweep.
        ram_we = 1'b1;
        wr_addr = 8'h55;
        wr_val = 2'b01;
        tick();
        chk("pre-abort ship", ship_cells, 1);
        ram_we = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        repeat (40) tick();
        chk("mid-sweep busy", busy, 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort busy", busy, 0);
        chk("abort ship", ship_cells, 0);
        chk("abort rd_valid", rd_valid, 0);
        chk("abort rd_val", rd_val, 0);
        chk("abort rd_oob", rd_oob, 0);
        chk("abort vid_val", vid_val, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 10; r++) begin
            for (int c = 0; c < 10; c++) begin
                vid_addr = {4'(r), 4'(c)};
                tick();
                chk($sformatf("zeroed vid %0d,%0d", r, c), vid_val, 0);
            end
        end
        chk("after abort busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, failures);
        $finish;
    end

endmodule
